// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
//   Handshake bundle for the bit-serial adder.
//
//   Upstream (operand) side:
//     in_valid   operand pair and cin are valid
//     in_ready   adder can accept an operand pair
//     a, b       WIDTH-bit operands
//     cin        carry into bit 0
//   Downstream (result) side:
//     out_valid  sum/cout are valid
//     out_ready  consumer accepts the result
//     sum        WIDTH-bit sum, a+b+cin truncated
//     cout       carry out of the MSB
//     ovf        signed overflow flag (present only with SERIAL_ADDER_OVF_EN)
//   Status:
//     busy       high while bits are being shifted through the full adder
//
//   Modports: slave = the adder, master = the party driving operands and
//   consuming results.
// -----------------------------------------------------------------------------
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy, ovf
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy, ovf
    );
`else
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder: one full-adder cell plus a registered carry,
//   consuming one bit per clock, LSB first. Operands arrive over a valid/ready
//   handshake, the registered sum and carry-out leave over another.
//
//   Parameters:
//     WIDTH      operand/sum width, 2..32
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     bus        serial_adder_if.slave (in_valid/in_ready/a/b/cin,
//                out_valid/out_ready/sum/cout, busy[, ovf])
//
//   Optional feature, macro SERIAL_ADDER_OVF_EN:
//     adds bus.ovf, the two's-complement overflow flag (carry into MSB XOR
//     carry out of MSB), captured on the last shift edge.
//
//   Timing: out_valid rises exactly WIDTH edges after the accepting edge;
//   result is held under backpressure; after the output handshake the block
//   returns to IDLE, so in_ready is seen one cycle later.
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);
    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic [CNT_W-1:0] cnt;

    logic             bit_sum;
    logic             bit_carry;
    logic             last;

    logic             in_ready;
    logic             out_valid;
    logic             busy;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Single full-adder cell working on the current LSBs and the carry register.
    assign bit_sum   = a_sr[0] ^ b_sr[0] ^ carry;
    assign bit_carry = majority(a_sr[0], b_sr[0], carry);
    assign last      = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // No same-cycle restart: IDLE is always visited after a result.
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= bit_carry;
                    // Sum bits enter at the MSB so that after WIDTH shifts
                    // bit 0 of the result has reached position 0.
                    sum_r <= {bit_sum, sum_r[WIDTH-1:1]};
                    if (last) begin
                        cout_r <= bit_carry;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry currently holds the carry into the MSB.
                        ovf_r  <= carry ^ bit_carry;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = ovf_r;
`endif

endmodule
